ysyx_22050133_axi_lsu_ctrl: RTL and testbench

Single-outstanding AXI4 master controller that sequences a simple core-side load/store request into one single-beat AXI read or write transaction. It captures the request, drives the AR/R or AW/W/B handshakes, and returns data or status through a valid/ready response port. One instance sits behind the LSU and one behind instruction fetch. Each drives one slave port of the IF/MEM AXI arbiter.

---
 rtl/ysyx_22050133_axi_pkg.sv | 27 ++
 rtl/ysyx_22050133_axi_lsu_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_ysyx_22050133_axi_lsu_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050133_axi_pkg.sv
// Shared definitions for the single-outstanding AXI4 master controllers.
// Holds the controller state encoding and the AXI burst, response and size
// constants used by the IF and LSU controller instances.
package ysyx_22050133_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4,
        ST_RESP  = 3'd5
    } lsu_state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

endpackage

// File: rtl/ysyx_22050133_axi_lsu_ctrl.sv
// Single-outstanding AXI4 master controller.
// Turns one core-side load/store request into one single-beat AXI read
// (AR/R) or write (AW/W/B) and returns data/status on a valid/ready port.
// Ports:
//   clk, rst (async, active low)
//   req_*  : core request (valid/ready, wen, addr, size, wdata, wstrb)
//   resp_* : core response (valid/ready, rdata, err)
//   aw_*/w_*/b_* : AXI write channels, ar_*/r_* : AXI read channels
module ysyx_22050133_axi_lsu_ctrl
    import ysyx_22050133_axi_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic                        req_wen_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2:0]                  req_size_i,
    input  logic [AXI_DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] req_wstrb_i,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   resp_rdata_o,
    output logic                        resp_err_o,
    output logic                        aw_valid_o,
    input  logic                        aw_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   aw_addr_o,
    output logic [7:0]                  aw_len_o,
    output logic [2:0]                  aw_size_o,
    output logic [1:0]                  aw_burst_o,
    output logic                        w_valid_o,
    input  logic                        w_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
    output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
    output logic                        w_last_o,
    input  logic                        b_valid_i,
    output logic                        b_ready_o,
    input  logic [1:0]                  b_resp_i,
    output logic                        ar_valid_o,
    input  logic                        ar_ready_i,
    output logic [AXI_ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [7:0]                  ar_len_o,
    output logic [2:0]                  ar_size_o,
    output logic [1:0]                  ar_burst_o,
    input  logic                        r_valid_i,
    output logic                        r_ready_o,
    input  logic [1:0]                  r_resp_i,
    input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
    input  logic                        r_last_i
);

    localparam int         STRB_W   = AXI_DATA_WIDTH / 8;
    // Largest legal AXI size: one full data-bus beat.
    localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));

    lsu_state_e                state_reg, state_next;
    logic [AXI_ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [2:0]                size_reg, size_next;
    logic [1:0]                burst_reg, burst_next;
    logic [AXI_DATA_WIDTH-1:0] wdata_reg, wdata_next;
    logic [STRB_W-1:0]         wstrb_reg, wstrb_next;
    logic [AXI_DATA_WIDTH-1:0] rdata_reg, rdata_next;
    logic                      err_reg, err_next;
    logic                      aw_done_reg, aw_done_next;
    logic                      w_done_reg, w_done_next;
    logic                      req_ready_reg, req_ready_next;
    logic                      ar_valid_reg, ar_valid_next;
    logic                      r_ready_reg, r_ready_next;
    logic                      aw_valid_reg, aw_valid_next;
    logic                      w_valid_reg, w_valid_next;
    logic                      b_ready_reg, b_ready_next;
    logic                      resp_valid_reg, resp_valid_next;

    logic aw_fire, w_fire;
    assign aw_fire = aw_valid_reg & aw_ready_i;
    assign w_fire  = w_valid_reg & w_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            size_reg       <= '0;
            burst_reg      <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            rdata_reg      <= '0;
            err_reg        <= 1'b0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
            req_ready_reg  <= 1'b0;
            ar_valid_reg   <= 1'b0;
            r_ready_reg    <= 1'b0;
            aw_valid_reg   <= 1'b0;
            w_valid_reg    <= 1'b0;
            b_ready_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            size_reg       <= size_next;
            burst_reg      <= burst_next;
            wdata_reg      <= wdata_next;
            wstrb_reg      <= wstrb_next;
            rdata_reg      <= rdata_next;
            err_reg        <= err_next;
            aw_done_reg    <= aw_done_next;
            w_done_reg     <= w_done_next;
            req_ready_reg  <= req_ready_next;
            ar_valid_reg   <= ar_valid_next;
            r_ready_reg    <= r_ready_next;
            aw_valid_reg   <= aw_valid_next;
            w_valid_reg    <= w_valid_next;
            b_ready_reg    <= b_ready_next;
            resp_valid_reg <= resp_valid_next;
        end
    end

    // Every handshake output is a registered "_next" so no valid ever
    // combinationally depends on its ready.
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        size_next       = size_reg;
        burst_next      = burst_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        rdata_next      = rdata_reg;
        err_next        = err_reg;
        aw_done_next    = aw_done_reg;
        w_done_next     = w_done_reg;
        req_ready_next  = req_ready_reg;
        ar_valid_next   = ar_valid_reg;
        r_ready_next    = r_ready_reg;
        aw_valid_next   = aw_valid_reg;
        w_valid_next    = w_valid_reg;
        b_ready_next    = b_ready_reg;
        resp_valid_next = resp_valid_reg;

        case (state_reg)
            ST_IDLE: begin
                // req_ready comes up one cycle after reset release.
                req_ready_next = 1'b1;
                if (req_valid_i && req_ready_reg) begin
                    addr_next      = req_addr_i;
                    size_next      = req_size_i;
                    wdata_next     = req_wdata_i;
                    wstrb_next     = req_wstrb_i;
                    burst_next     = AXI_BURST_INCR;
                    rdata_next     = '0;
                    err_next       = 1'b0;
                    req_ready_next = 1'b0;
                    if (req_size_i > SIZE_MAX) begin
                        // Oversized access: answer with an error, no bus cycle.
                        err_next        = 1'b1;
                        resp_valid_next = 1'b1;
                        state_next      = ST_RESP;
                    end else if (req_wen_i) begin
                        aw_valid_next = 1'b1;
                        w_valid_next  = 1'b1;
                        aw_done_next  = 1'b0;
                        w_done_next   = 1'b0;
                        state_next    = ST_WADDR;
                    end else begin
                        ar_valid_next = 1'b1;
                        state_next    = ST_RADDR;
                    end
                end
            end
            ST_RADDR: begin
                if (ar_valid_reg && ar_ready_i) begin
                    ar_valid_next = 1'b0;
                    r_ready_next  = 1'b1;
                    state_next    = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (r_ready_reg && r_valid_i) begin
                    if (r_resp_i != AXI_RESP_OKAY) begin
                        err_next = 1'b1;
                    end
                    // Non-last beats are swallowed so a bad slave can't hang us.
                    if (r_last_i) begin
                        rdata_next      = r_data_i;
                        r_ready_next    = 1'b0;
                        resp_valid_next = 1'b1;
                        state_next      = ST_RESP;
                    end
                end
            end
            ST_WADDR: begin
                if (aw_fire) begin
                    aw_valid_next = 1'b0;
                    aw_done_next  = 1'b1;
                end
                if (w_fire) begin
                    w_valid_next = 1'b0;
                    w_done_next  = 1'b1;
                end
                if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) begin
                    b_ready_next = 1'b1;
                    state_next   = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_ready_reg && b_valid_i) begin
                    if (b_resp_i != AXI_RESP_OKAY) begin
                        err_next = 1'b1;
                    end
                    rdata_next      = '0;
                    b_ready_next    = 1'b0;
                    resp_valid_next = 1'b1;
                    state_next      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_next = 1'b0;
                    req_ready_next  = 1'b1;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o  = req_ready_reg;
    assign resp_valid_o = resp_valid_reg;
    assign resp_rdata_o = rdata_reg;
    assign resp_err_o   = err_reg;

    assign aw_valid_o = aw_valid_reg;
    assign aw_addr_o  = addr_reg;
    assign aw_len_o   = 8'd0;
    assign aw_size_o  = size_reg;
    assign aw_burst_o = burst_reg;

    assign w_valid_o = w_valid_reg;
    assign w_data_o  = wdata_reg;
    assign w_strb_o  = wstrb_reg;
    assign w_last_o  = w_valid_reg;

    assign b_ready_o = b_ready_reg;

    assign ar_valid_o = ar_valid_reg;
    assign ar_addr_o  = addr_reg;
    assign ar_len_o   = 8'd0;
    assign ar_size_o  = size_reg;
    assign ar_burst_o = burst_reg;

    assign r_ready_o = r_ready_reg;

endmodule

// File: tb/tb_ysyx_22050133_axi_lsu_ctrl.sv
// Directed bench for ysyx_22050133_axi_lsu_ctrl: a table of zero-wait
// transactions plus hand-written stall, error, multi-beat and reset sequences.
module tb_ysyx_22050133_axi_lsu_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_wen_i;
    logic [31:0] req_addr_i;
    logic [2:0]  req_size_i;
    logic [63:0] req_wdata_i;
    logic [7:0]  req_wstrb_i;
    logic        resp_valid_o, resp_ready_i, resp_err_o;
    logic [63:0] resp_rdata_o;
    logic        aw_valid_o, aw_ready_i;
    logic [31:0] aw_addr_o;
    logic [7:0]  aw_len_o;
    logic [2:0]  aw_size_o;
    logic [1:0]  aw_burst_o;
    logic        w_valid_o, w_ready_i, w_last_o;
    logic [63:0] w_data_o;
    logic [7:0]  w_strb_o;
    logic        b_valid_i, b_ready_o;
    logic [1:0]  b_resp_i;
    logic        ar_valid_o, ar_ready_i;
    logic [31:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        r_valid_i, r_ready_o, r_last_i;
    logic [1:0]  r_resp_i;
    logic [63:0] r_data_i;

    int errors = 0;
    int checks = 0;

    ysyx_22050133_axi_lsu_ctrl #(.AXI_DATA_WIDTH(64), .AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o),
        .aw_len_o(aw_len_o), .aw_size_o(aw_size_o), .aw_burst_o(aw_burst_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_burst_o(ar_burst_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_resp_i(r_resp_i),
        .r_data_i(r_data_i), .r_last_i(r_last_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] slv_data;
        logic [1:0]  slv_resp;
        logic        exp_illegal;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request in the current cycle; returns one cycle after acceptance.
    task automatic start_req(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                             input logic [63:0] wdata, input logic [7:0] wstrb);
        req_valid_i = 1'b1;
        req_wen_i   = wen;
        req_addr_i  = addr;
        req_size_i  = size;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        chk("req_ready_at_issue", req_ready_o, 1'b1);
        step();
        req_valid_i = 1'b0;
    endtask

    // Zero-wait slave run of one table entry with cycle-exact checks.
    task automatic run_vec(input vec_t v, input int idx);
        start_req(v.wen, v.addr, v.size, v.wdata, v.wstrb);
        chk("req_ready_busy", req_ready_o, 1'b0);
        if (v.exp_illegal) begin
            chk("illegal_no_ar", ar_valid_o, 1'b0);
            chk("illegal_no_aw", aw_valid_o, 1'b0);
        end else if (v.wen) begin
            chk("aw_valid_t1", aw_valid_o, 1'b1);
            chk("w_valid_t1", w_valid_o, 1'b1);
            chk("w_last_t1", w_last_o, 1'b1);
            chk("aw_addr", aw_addr_o, v.addr);
            chk("aw_size", aw_size_o, v.size);
            chk("aw_len", aw_len_o, 8'd0);
            chk("aw_burst", aw_burst_o, 2'b01);
            chk("w_data", w_data_o, v.wdata);
            chk("w_strb", w_strb_o, v.wstrb);
            aw_ready_i = 1'b1;
            w_ready_i  = 1'b1;
            step();
            aw_ready_i = 1'b0;
            w_ready_i  = 1'b0;
            chk("aw_valid_drop", aw_valid_o, 1'b0);
            chk("w_valid_drop", w_valid_o, 1'b0);
            chk("b_ready_t2", b_ready_o, 1'b1);
            b_valid_i = 1'b1;
            b_resp_i  = v.slv_resp;
            step();
            b_valid_i = 1'b0;
            chk("b_ready_drop", b_ready_o, 1'b0);
        end else begin
            chk("ar_valid_t1", ar_valid_o, 1'b1);
            chk("ar_addr", ar_addr_o, v.addr);
            chk("ar_size", ar_size_o, v.size);
            chk("ar_len", ar_len_o, 8'd0);
            chk("ar_burst", ar_burst_o, 2'b01);
            chk("resp_valid_t1", resp_valid_o, 1'b0);
            ar_ready_i = 1'b1;
            step();
            ar_ready_i = 1'b0;
            chk("ar_valid_drop", ar_valid_o, 1'b0);
            chk("r_ready_t2", r_ready_o, 1'b1);
            r_valid_i = 1'b1;
            r_data_i  = v.slv_data;
            r_resp_i  = v.slv_resp;
            r_last_i  = 1'b1;
            step();
            r_valid_i = 1'b0;
            r_last_i  = 1'b0;
            chk("r_ready_drop", r_ready_o, 1'b0);
        end
        chk("resp_valid", resp_valid_o, 1'b1);
        chk("resp_rdata", resp_rdata_o, v.exp_rdata);
        chk("resp_err", resp_err_o, v.exp_err);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        chk("resp_valid_drop", resp_valid_o, 1'b0);
        chk("req_ready_back", req_ready_o, 1'b1);
        $display("txn %0d: wen=%0b addr=0x%08h size=%0d rdata=0x%016h err=%0b",
                 idx, v.wen, v.addr, v.size, resp_rdata_o, resp_err_o);
    endtask

    initial begin
        //                 wen  addr          size  wdata                  wstrb  slv_data               resp   ill   exp_rdata              err
        vecs[0] = '{1'b0, 32'h8000_0010, 3'd3, 64'h0,                 8'h00, 64'hDEAD_BEEF_0123_4567, 2'b00, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0};
        vecs[1] = '{1'b0, 32'h8000_0004, 3'd2, 64'h0,                 8'h00, 64'h0000_0000_0000_1234, 2'b10, 1'b0, 64'h0000_0000_0000_1234, 1'b1};
        vecs[2] = '{1'b1, 32'h8000_0100, 3'd3, 64'h0102_0304_0506_0708, 8'hFF, 64'h0,                 2'b00, 1'b0, 64'h0,                 1'b0};
        vecs[3] = '{1'b1, 32'h8000_0203, 3'd0, 64'h0000_0000_AB00_0000, 8'h08, 64'h0,                 2'b11, 1'b0, 64'h0,                 1'b1};
        vecs[4] = '{1'b0, 32'h8000_0020, 3'd4, 64'h0,                 8'h00, 64'h0,                 2'b00, 1'b1, 64'h0,                 1'b1};
        vecs[5] = '{1'b1, 32'h8000_0030, 3'd7, 64'h5A5A,              8'h03, 64'h0,                 2'b00, 1'b1, 64'h0,                 1'b1};
        vecs[6] = '{1'b0, 32'h8000_0040, 3'd1, 64'h0,                 8'h00, 64'h0000_0000_0000_BEEF, 2'b01, 1'b0, 64'h0000_0000_0000_BEEF, 1'b1};

        rst = 1'b0;
        req_valid_i = 0; req_wen_i = 0; req_addr_i = 0; req_size_i = 0;
        req_wdata_i = 0; req_wstrb_i = 0; resp_ready_i = 0;
        aw_ready_i = 0; w_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
        ar_ready_i = 0; r_valid_i = 0; r_resp_i = 0; r_data_i = 0; r_last_i = 0;

        step();
        step();
        chk("rst_req_ready", req_ready_o, 1'b0);
        chk("rst_resp_valid", resp_valid_o, 1'b0);
        chk("rst_ar_valid", ar_valid_o, 1'b0);
        chk("rst_aw_valid", aw_valid_o, 1'b0);
        chk("rst_w_valid", w_valid_o, 1'b0);
        chk("rst_r_ready", r_ready_o, 1'b0);
        chk("rst_b_ready", b_ready_o, 1'b0);
        chk("rst_rdata", resp_rdata_o, 64'h0);
        chk("rst_err", resp_err_o, 1'b0);
        chk("rst_ar_size_burst", {ar_size_o, ar_burst_o, ar_len_o}, 13'h0);
        chk("rst_aw_size_burst", {aw_size_o, aw_burst_o, aw_len_o}, 13'h0);
        rst = 1'b1;
        step();
        chk("req_ready_after_rst", req_ready_o, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Write with W delayed 3 cycles behind AW.
        start_req(1'b1, 32'h8000_0300, 3'd3, 64'h1122_3344_5566_7788, 8'hF0);
        chk("stall_aw_valid_t1", aw_valid_o, 1'b1);
        chk("stall_w_valid_t1", w_valid_o, 1'b1);
        aw_ready_i = 1'b1;
        step();
        aw_ready_i = 1'b0;
        chk("stall_aw_drop", aw_valid_o, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_w_held", w_valid_o, 1'b1);
            chk("stall_w_data_held", w_data_o, 64'h1122_3344_5566_7788);
            chk("stall_w_strb_held", w_strb_o, 8'hF0);
            chk("stall_b_ready_low", b_ready_o, 1'b0);
            if (c == 2) w_ready_i = 1'b1;
            step();
        end
        w_ready_i = 1'b0;
        chk("stall_w_drop", w_valid_o, 1'b0);
        chk("stall_b_ready", b_ready_o, 1'b1);
        b_valid_i = 1'b1;
        b_resp_i  = 2'b00;
        step();
        b_valid_i = 1'b0;
        chk("stall_resp_valid", resp_valid_o, 1'b1);
        chk("stall_resp_err", resp_err_o, 1'b0);
        chk("stall_resp_rdata", resp_rdata_o, 64'h0);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        $display("txn stall-w: err=%0b", resp_err_o);

        // Write with SLVERR and a response held off for 5 cycles.
        start_req(1'b1, 32'h8000_0400, 3'd2, 64'h0000_0000_CAFE_F00D, 8'h0F);
        aw_ready_i = 1'b1;
        w_ready_i  = 1'b1;
        step();
        aw_ready_i = 1'b0;
        w_ready_i  = 1'b0;
        b_valid_i  = 1'b1;
        b_resp_i   = 2'b10;
        step();
        b_valid_i = 1'b0;
        b_resp_i  = 2'b00;
        for (int c = 0; c < 6; c++) begin
            chk("hold_resp_valid", resp_valid_o, 1'b1);
            chk("hold_resp_err", resp_err_o, 1'b1);
            chk("hold_req_ready_low", req_ready_o, 1'b0);
            if (c == 5) resp_ready_i = 1'b1;
            step();
        end
        resp_ready_i = 1'b0;
        chk("hold_resp_drop", resp_valid_o, 1'b0);
        chk("hold_req_ready_back", req_ready_o, 1'b1);
        $display("txn slverr-hold: done");

        // Two-beat read: first beat (no last) is discarded.
        start_req(1'b0, 32'h8000_0500, 3'd3, 64'h0, 8'h00);
        ar_ready_i = 1'b1;
        step();
        ar_ready_i = 1'b0;
        r_valid_i  = 1'b1;
        r_data_i   = 64'hAAAA;
        r_resp_i   = 2'b00;
        r_last_i   = 1'b0;
        step();
        chk("beat1_r_ready_held", r_ready_o, 1'b1);
        chk("beat1_no_resp", resp_valid_o, 1'b0);
        r_data_i = 64'h5555;
        r_last_i = 1'b1;
        step();
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
        chk("beat2_resp_valid", resp_valid_o, 1'b1);
        chk("beat2_rdata", resp_rdata_o, 64'h5555);
        chk("beat2_err", resp_err_o, 1'b0);
        resp_ready_i = 1'b1;
        step();
        resp_ready_i = 1'b0;
        $display("txn two-beat: rdata=0x%0h", resp_rdata_o);

        // Reset while waiting in RDATA.
        start_req(1'b0, 32'h8000_0600, 3'd3, 64'h0, 8'h00);
        ar_ready_i = 1'b1;
        step();
        ar_ready_i = 1'b0;
        chk("pre_rst_r_ready", r_ready_o, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_r_ready", r_ready_o, 1'b0);
        chk("async_rst_req_ready", req_ready_o, 1'b0);
        chk("async_rst_resp_valid", resp_valid_o, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_req_ready", req_ready_o, 1'b1);
        chk("post_rst_r_ready", r_ready_o, 1'b0);
        $display("txn mid-rdata reset: done");
        run_vec(vecs[0], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
